// File: rtl/alu_cmd_host.sv
// Host-side initiator for the UART ALU byte protocol: serializes one command into a
// 12-byte request, then gathers the 4-byte little-endian result or times out.
module alu_cmd_host #(
    parameter int datawidth_p = 8,
    parameter int timeout_p   = 3317800
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [7:0]             cmd_op_i,
    input  logic [31:0]            cmd_a_i,
    input  logic [31:0]            cmd_b_i,
    output logic [datawidth_p-1:0] tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [datawidth_p-1:0] rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_timeout_o,
    output logic                   busy_o
);

    localparam int timer_w_lp = $clog2(timeout_p + 1);
    localparam logic [timer_w_lp-1:0] timer_last_lp = timer_w_lp'(timeout_p - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RX,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [timer_w_lp-1:0] timer_q, timer_d;
    logic [7:0]            op_q, op_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    logic [31:0]           result_q, result_d;
    logic                  timeout_q, timeout_d;

    logic [7:0]            pkt_byte;
    logic [3:0]            lane_we;

    // Request packet: opcode, reserved 0x00, length 12 (LSB first), A then B little-endian.
    always_comb begin
        pkt_byte = 8'h00;
        case (idx_q)
            4'd0:    pkt_byte = op_q;
            4'd2:    pkt_byte = 8'h0C;
            4'd4:    pkt_byte = a_q[7:0];
            4'd5:    pkt_byte = a_q[15:8];
            4'd6:    pkt_byte = a_q[23:16];
            4'd7:    pkt_byte = a_q[31:24];
            4'd8:    pkt_byte = b_q[7:0];
            4'd9:    pkt_byte = b_q[15:8];
            4'd10:   pkt_byte = b_q[23:16];
            4'd11:   pkt_byte = b_q[31:24];
            default: pkt_byte = 8'h00;
        endcase
    end

    // Response byte k lands in lane k; only bytes accepted in WAIT_RX are kept.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = (state_q == WAIT_RX) && rx_valid_i && (idx_q[1:0] == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_d      = cmd_op_i;
                    a_d       = cmd_a_i;
                    b_d       = cmd_b_i;
                    idx_d     = 4'd0;
                    result_d  = 32'h0;
                    timeout_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_ready_i) begin
                    if (idx_q == 4'd11) begin
                        idx_d   = 4'd0;
                        timer_d = '0;
                        state_d = WAIT_RX;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            WAIT_RX: begin
                // An accepted byte beats an expiring timer in the same cycle.
                if (rx_valid_i) begin
                    idx_d   = idx_q + 4'd1;
                    timer_d = '0;
                    if (idx_q == 4'd3) begin
                        timeout_d = 1'b0;
                        state_d   = DONE;
                    end
                end else if (timer_q == timer_last_lp) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    timer_d = timer_q + timer_w_lp'(1);
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                result_d[8*k +: 8] = rx_data_i[7:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            timer_q   <= '0;
            op_q      <= 8'h00;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            result_q  <= 32'h0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign tx_valid_o    = (state_q == SEND);
    assign tx_data_o     = (state_q == SEND) ? datawidth_p'(pkt_byte) : '0;
    assign rx_ready_o    = 1'b1;
    assign rsp_valid_o   = (state_q == DONE);
    assign rsp_data_o    = result_q;
    assign rsp_timeout_o = timeout_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_host.sv
// Randomized scoreboard bench for alu_cmd_host: expected request bytes and responses are
// queued by the stimulus and popped by independent tx/rsp monitors.
module tb_alu_cmd_host;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  cmd_op_i = 8'h00;
    logic [31:0] cmd_a_i = 32'h0;
    logic [31:0] cmd_b_i = 32'h0;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_data[$];
    logic        exp_to[$];

    bit bp_mode = 1'b0;
    bit tx_hold = 1'b0;

    alu_cmd_host #(.datawidth_p(8), .timeout_p(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Reference model: packet and response derived straight from the protocol rules.
    function automatic void push_pkt(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_tx.push_back(op);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'd12);
        exp_tx.push_back(8'h00);
        for (int k = 0; k < 4; k++) exp_tx.push_back(8'((a >> (8 * k)) & 32'hFF));
        for (int k = 0; k < 4; k++) exp_tx.push_back(8'((b >> (8 * k)) & 32'hFF));
    endfunction

    function automatic logic [31:0] rsp_value(input logic [7:0] bytes[$]);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < bytes.size() && k < 4; k++) v = v + (32'(bytes[k]) << (8 * k));
        return v;
    endfunction

    function automatic void push_rsp(input logic [7:0] bytes[$]);
        exp_data.push_back(rsp_value(bytes));
        exp_to.push_back(bytes.size() < 4);
    endfunction

    // tx_ready driver: tied high, random under backpressure, forced low on request.
    initial forever begin
        @(posedge clk_i);
        #1;
        tx_ready_i = tx_hold ? 1'b0 : (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // tx monitor: every handshaked byte must be the next expected one; stalled bytes must hold.
    bit         stall_pending = 1'b0;
    logic [7:0] stall_data = 8'h00;
    initial forever begin
        @(negedge clk_i);
        if (stall_pending) begin
            chk("tx_stall_hold", {tx_valid_o, tx_data_o}, {1'b1, stall_data});
            stall_pending = 1'b0;
        end
        if (tx_valid_o && tx_ready_i && !rst_i) begin
            if (exp_tx.size() == 0) chk("tx_unexpected_byte", {1'b1, tx_data_o}, 9'h0);
            else chk("tx_byte", tx_data_o, exp_tx.pop_front());
        end else if (tx_valid_o && !tx_ready_i && !rst_i) begin
            stall_pending = 1'b1;
            stall_data    = tx_data_o;
        end
    end

    // Response monitor.
    initial forever begin
        @(negedge clk_i);
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_data.size() == 0) begin
                chk("rsp_unexpected", rsp_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("rsp_data", rsp_data_o, exp_data.pop_front());
                chk("rsp_timeout", rsp_timeout_o, exp_to.pop_front());
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk_i);
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_accept(output int acc);
        int n = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk("cmd_accept_bound", cmd_ready_o, 1'b1);
        acc = cyc;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic issue_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int acc);
        push_pkt(op, a, b);
        cmd_op_i    = op;
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_valid_i = 1'b1;
        wait_accept(acc);
    endtask

    task automatic wait_tx_done();
        int n = 0;
        @(negedge clk_i);
        while (!(busy_o && !tx_valid_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 500) chk("tx_done_bound", tx_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic check_reset(input string name);
        chk(name, {cmd_ready_o, tx_valid_o, tx_data_o, rx_ready_o, rsp_valid_o, rsp_timeout_o,
                   busy_o, rsp_data_o},
            {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    endtask

    initial begin
        int          acc, rel, n;
        bit          early;
        logic [7:0]  bq[$];
        logic [31:0] a, b, hold_exp;
        logic [7:0]  op;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset("reset_state");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Add with latency checks.
        issue_cmd(8'hA0, 32'h5, 32'h7, acc);
        @(negedge clk_i);
        chk("first_byte_latency", {tx_valid_o, tx_data_o}, {1'b1, 8'hA0});
        while (cyc < acc + 12) @(negedge clk_i);
        chk("byte11_cycle", {tx_valid_o, tx_data_o}, {1'b1, 8'h00});
        @(negedge clk_i);
        chk("wait_rx_cycle", {tx_valid_o, busy_o, rsp_valid_o, rx_ready_o}, 4'b0101);
        @(posedge clk_i);
        #1;
        bq = '{8'h0C, 8'h00, 8'h00, 8'h00};
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);
        @(negedge clk_i);
        chk("rsp_latency", {rsp_valid_o, rsp_data_o}, {1'b1, 32'h0000000C});
        @(posedge clk_i);
        #1;

        // Backpressure on the request stream.
        bp_mode = 1'b1;
        issue_cmd(8'hA1, 32'h12345678, 32'hDEADBEEF, acc);
        wait_tx_done();
        bp_mode = 1'b0;
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);

        // Timeout after two bytes.
        issue_cmd(8'hA2, $urandom, $urandom, acc);
        wait_tx_done();
        bq = '{8'hAA, 8'hBB};
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);
        early = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk_i);
            early = early | rsp_valid_o;
            @(posedge clk_i);
            #1;
        end
        chk("timeout_not_early", early, 1'b0);
        @(negedge clk_i);
        chk("timeout_fire", {rsp_valid_o, rsp_timeout_o, rsp_data_o}, {1'b1, 1'b1, 32'h0000BBAA});
        @(posedge clk_i);
        #1;

        // Stray bytes in IDLE and SEND are discarded.
        rx_send(8'h55);
        issue_cmd(8'hA0, $urandom, $urandom, acc);
        rx_send(8'h55);
        wait_tx_done();
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);
        @(negedge clk_i);
        chk("stray_result", rsp_data_o, 32'h04030201);
        @(posedge clk_i);
        #1;

        // Response hold while the consumer stalls and a new command waits.
        issue_cmd(8'hA1, $urandom, $urandom, acc);
        wait_tx_done();
        rsp_ready_i = 1'b0;
        bq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        hold_exp = rsp_value(bq);
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);
        op = 8'hA2;
        a  = $urandom;
        b  = $urandom;
        push_pkt(op, a, b);
        cmd_op_i    = op;
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("rsp_hold", {rsp_valid_o, cmd_ready_o, rsp_data_o}, {1'b1, 1'b0, hold_exp});
            @(posedge clk_i);
            #1;
        end
        rel = cyc;
        rsp_ready_i = 1'b1;
        wait_accept(acc);
        chk("idle_after_rsp", acc, rel + 1);
        wait_tx_done();
        bq = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);

        // Reset mid-packet after byte 5.
        a = 32'hC3B2A190;
        issue_cmd(8'hA0, a, $urandom, acc);
        repeat (6) void'(exp_tx.pop_back());
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        tx_hold = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("pre_reset_byte6", {tx_valid_o, tx_data_o}, {1'b1, a[23:16]});
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset("reset_mid_packet");
        @(posedge clk_i);
        #1;
        tx_hold = 1'b0;
        issue_cmd(8'hA1, $urandom, $urandom, acc);
        wait_tx_done();
        bq = '{8'h21, 8'h43, 8'h65, 8'h87};
        push_rsp(bq);
        foreach (bq[i]) rx_send(bq[i]);

        // Randomized transactions, including short responses that time out.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0: op = 8'hA0;
                1: op = 8'hA1;
                2: op = 8'hA2;
                default: op = 8'($urandom);
            endcase
            bp_mode = 1'($urandom_range(0, 1));
            issue_cmd(op, $urandom, $urandom, acc);
            if ($urandom_range(0, 2) == 0) rx_send(8'($urandom));
            wait_tx_done();
            bp_mode = 1'b0;
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4;
            bq.delete();
            for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
            push_rsp(bq);
            foreach (bq[i]) begin
                repeat ($urandom_range(0, 12)) begin
                    @(posedge clk_i);
                    #1;
                end
                rx_send(bq[i]);
            end
        end

        n = 0;
        @(negedge clk_i);
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("final_idle", busy_o, 1'b0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("rsp_queue_drained", exp_data.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_host.md
# alu_cmd_host

Host-side initiator for the UART ALU byte protocol: accepts one ALU command (opcode plus two 32-bit operands) on a valid/ready interface, serializes it into a 12-byte request packet on a byte stream toward a UART transmitter, then collects the 4-byte little-endian result from a UART receiver byte stream and presents it as a single response. It sits at the far end of the serial link from the ALU (a host FPGA, or a loopback bench driving the ALU). It instantiates no UART; its byte ports connect directly to the AXI-Stream sides of the existing `uart_tx` / `uart_rx` cores.

## Interface
- `datawidth_p`, 8, byte-stream width; only 8 is supported.
- `timeout_p`, 3317800, idle cycles allowed between response bytes before abort (100 ms at 33.178 MHz); must be ≥ 2.

- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  block can accept a command.
- `cmd_op_i`  in  8  opcode byte, e.g. 0xA0 add, 0xA1 mul, 0xA2 div; sent unmodified.
- `cmd_a_i`  in  32  operand A.
- `cmd_b_i`  in  32  operand B.
- `tx_data_o`  out  8  request byte to `uart_tx` `s_axis_tdata`.
- `tx_valid_o`  out  1  request byte valid.
- `tx_ready_i`  in  1  `uart_tx` accepts the byte.
- `rx_data_i`  in  8  response byte from `uart_rx` `m_axis_tdata`.
- `rx_valid_i`  in  1  response byte valid.
- `rx_ready_o`  out  1  block accepts the response byte.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  consumer takes the response.
- `rsp_data_o`  out  32  result, little-endian assembled.
- `rsp_timeout_o`  out  1  response ended by timeout; qualified by `rsp_valid_o`.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Request packet, 12 bytes, in order:
  - byte 0: opcode.
  - byte 1: 0x00.
  - bytes 2–3: packet length 0x0C, 0x00 (LSB first).
  - bytes 4–7: A[7:0]..A[31:24].
  - bytes 8–11: B[7:0]..B[31:24].
- Response: 4 bytes; byte k lands in `rsp_data_o[8k+7:8k]`.
- States:
  - IDLE: `cmd_ready_o`=1. On `cmd_valid_i & cmd_ready_o`, latch opcode, A and B, clear byte index, clear the result register → SEND.
  - SEND: `tx_valid_o`=1 and `tx_data_o` = packet[index]. On `tx_ready_i`, index++. On the handshake of byte 11 → WAIT_RX, with index cleared and timer cleared.
  - WAIT_RX: on an accepted rx byte, store it at index, index++ and clear the timer; otherwise timer++. The 4th accepted byte → DONE with `rsp_timeout_o`=0. Timer reaching `timeout_p` → DONE with `rsp_timeout_o`=1.
  - DONE: `rsp_valid_o`=1. `rsp_data_o` and `rsp_timeout_o` are held stable. On `rsp_ready_i` → IDLE.
- `rx_ready_o`=1 in all states. Bytes accepted outside WAIT_RX are discarded without side effects, which flushes stale or late bytes.
- On timeout, response bytes never received read as 0x00.
- Reset in any state, including mid-packet: → IDLE, index and timer cleared, result cleared. A partially sent packet is abandoned; the block does not recover it.

## Timing
- Reset values: `cmd_ready_o`=1 (IDLE), `tx_valid_o`=0, `tx_data_o`=0x00, `rx_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_timeout_o`=0, `busy_o`=0.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Command accepted in cycle N → `tx_valid_o`=1 with byte 0 in cycle N+1.
- With `tx_ready_i` tied high, byte k is presented in cycle N+1+k, and the block enters WAIT_RX in cycle N+13.
- `tx_data_o` and `tx_valid_o` hold until the handshake completes; `tx_valid_o` never drops mid-packet.
- Response byte 3 accepted in cycle M → `rsp_valid_o`=1 in M+1.
- Rsp handshake in cycle R → IDLE (`cmd_ready_o`=1) in R+1; back-to-back commands are therefore at least one idle cycle apart.
- Timeout: `timeout_p` consecutive WAIT_RX cycles without an accepted byte → `rsp_valid_o`=1 on the next cycle.
- A byte accepted in the same cycle the timer would expire takes priority; no timeout occurs in that cycle.

## Test plan
- Add: op 0xA0, A=0x00000005, B=0x00000007, `tx_ready_i`=1 → tx bytes A0 00 0C 00 05 00 00 00 07 00 00 00. Then inject 0C 00 00 00 → `rsp_data_o`=0x0000000C, `rsp_timeout_o`=0, latency counts exactly as in Timing.
- Backpressure: random `tx_ready_i`, A=0x12345678, B=0xDEADBEEF → byte order and values unchanged (…78 56 34 12 EF BE AD DE), `tx_data_o` stable while stalled.
- Timeout: `timeout_p`=16; after the request, inject only 0xAA, 0xBB → after 16 idle cycles `rsp_valid_o`=1, `rsp_timeout_o`=1, `rsp_data_o`=0x0000BBAA.
- Stray bytes: inject 0x55 in IDLE and during SEND, then a normal 4-byte response 01 02 03 04 → `rsp_data_o`=0x04030201.
- Response hold: `rsp_ready_i`=0 for 10 cycles with `cmd_valid_i`=1 → `rsp_valid_o` and data held, `cmd_ready_o`=0. Release → IDLE next cycle, new command accepted.
- Reset mid-packet: assert `rst_i` after byte 5 → next cycle all outputs at reset values. A new command then restarts from byte 0 (opcode).
